// File: rtl/line_code_pkg.sv
// Shared definitions for the line-code collector and its display-path users.
package line_code_pkg;

  // Bit position of the "five" flag and largest legal remainder value.
  localparam int unsigned LC_FIVE_BIT = 3;
  localparam int unsigned LC_REM_MAX  = 4;

  // Collector states.
  typedef enum logic {
    COLLECT = 1'b0,
    OUTPUT  = 1'b1
  } lc_state_e;

  // A code is legal when its remainder field is 0..4; the five flag may be either value.
  function automatic logic lc_is_legal(input logic [3:0] code);
    return (code[2:0] <= 3'(LC_REM_MAX));
  endfunction

endpackage

// File: rtl/line_code_digit.sv
// Combinational line-code to decimal digit decoder. Illegal codes decode to
// digit 0 with legal deasserted.
module line_code_digit
  import line_code_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [3:0] digit_o,
  output logic       legal_o
);

  // Decode: remainder, plus five when the five flag is set.
  always_comb begin
    legal_o = lc_is_legal(code_i);
    if (!legal_o) begin
      digit_o = 4'd0;
    end else if (code_i[LC_FIVE_BIT]) begin
      digit_o = 4'd5 + {1'b0, code_i[2:0]};
    end else begin
      digit_o = {1'b0, code_i[2:0]};
    end
  end

endmodule

// File: rtl/line_code_collector.sv
// Collects DIGITS line codes into a packed BCD frame (first digit in the MSB
// nibble) and hands it downstream over a valid/ready handshake. Illegal codes
// abort the frame in progress and pulse err.
// Optional build macro: LINE_ERR_COUNT_EN adds a saturating 8-bit err_count output.
module line_code_collector
  import line_code_pkg::*;
#(
  parameter int unsigned DIGITS = 4
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            code_in,
  input  logic                  code_valid,
  output logic                  code_ready,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  bcd_valid,
  input  logic                  bcd_ready,
  output logic                  err
`ifdef LINE_ERR_COUNT_EN
  ,
  output logic [7:0]            err_count
`endif
);

  localparam int unsigned ACC_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

  lc_state_e          state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   bcd_out_q;
  logic               bcd_valid_q;
  logic               err_q;
  logic               ready_q;

  logic [3:0]         digit_s;
  logic               legal_s;
  logic [ACC_W-1:0]   acc_shift_s;
  logic               illegal_xfer_s;

  line_code_digit u_digit (
    .code_i  (code_in),
    .digit_o (digit_s),
    .legal_o (legal_s)
  );

  // Accumulator with the incoming digit shifted into the LSB nibble.
  always_comb begin
    acc_shift_s = (acc_q << 4) | ACC_W'(digit_s);
  end

  // An illegal code is only taken in COLLECT when no clr is discarding it.
  always_comb begin
    if (!rst && (state_q == COLLECT) && code_valid && !clr && !legal_s) begin
      illegal_xfer_s = 1'b1;
    end else begin
      illegal_xfer_s = 1'b0;
    end
  end

  // Collector FSM with registered handshake outputs and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      acc_q       <= '0;
      bcd_out_q   <= '0;
      bcd_valid_q <= 1'b0;
      err_q       <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        COLLECT: begin
          if (clr) begin
            cnt_q <= '0;
            acc_q <= '0;
          end else if (code_valid) begin
            if (legal_s) begin
              acc_q <= acc_shift_s;
              cnt_q <= cnt_q + CNT_W'(1);
              if (cnt_q == CNT_LAST) begin
                bcd_out_q   <= acc_shift_s;
                bcd_valid_q <= 1'b1;
                ready_q     <= 1'b0;
                state_q     <= OUTPUT;
              end
            end else begin
              err_q <= 1'b1;
              cnt_q <= '0;
              acc_q <= '0;
            end
          end
        end
        OUTPUT: begin
          // clr is ignored here so a presented frame is never retracted.
          if (bcd_ready) begin
            bcd_valid_q <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            ready_q     <= 1'b1;
            state_q     <= COLLECT;
          end
        end
        default: begin
          state_q     <= COLLECT;
          cnt_q       <= '0;
          acc_q       <= '0;
          bcd_valid_q <= 1'b0;
          ready_q     <= 1'b1;
        end
      endcase
    end
  end

  assign code_ready = ready_q & ~rst;
  assign bcd_out    = bcd_out_q;
  assign bcd_valid  = bcd_valid_q;
  assign err        = err_q;

`ifdef LINE_ERR_COUNT_EN
  logic [7:0] err_count_q;
  logic [7:0] err_count_d;

  // Saturating count of illegal code transfers; clr leaves it untouched.
  always_comb begin
    if (illegal_xfer_s && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // Error counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q <= 8'd0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`else
  // Without the counter the illegal-transfer qualifier has no consumer.
  logic unused_s;
  assign unused_s = illegal_xfer_s;
`endif

endmodule
